multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Multi-cycle signed 32-bit multiply/divide unit for the processor's execute stage.
- Time-shares a single instance of the team's 32-bit carry-select adder across iterations.
- Radix-2 Booth multiply, 32 iterations; restoring divide on magnitudes with a final sign-fix pass.
- Issued by a one-cycle ctrl pulse; returns a one-cycle ready pulse.

Parameters:
- WIDTH, 32, operand/result width; the only supported value, because the adder is fixed at 32 bits.
- ITERS, 32, iteration count; must equal WIDTH.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ctrl_MULT  input  1  one-cycle pulse; start multiply.
- ctrl_DIV  input  1  one-cycle pulse; start divide.
- data_operandA  input  32  multiplicand/dividend, two's complement; sampled only on a start edge.
- data_operandB  input  32  multiplier/divisor, two's complement; sampled only on a start edge.
- data_result  output  32  product low word or quotient; held until next start.
- data_exception  output  1  overflow or divide-by-zero; held until next start.
- data_resultRDY  output  1  one-cycle pulse when result/exception become valid.
- busy  output  1  high from start edge until the edge that raises data_resultRDY.

Behaviour:
- Reset (async): state=IDLE, count=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0, all internal registers 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Start edge E0: ctrl_MULT or ctrl_DIV high → latch operands, count=0, data_resultRDY=0.
- Start arbitration: ctrl_MULT wins when both are high.
- Start while busy: abort the current operation and restart with new operands; the aborted op never raises RDY.
- MUL:
  - P={hi=0, lo=A, q=0}. Each edge E1..E32: {lo[0],q}=01 → hi+=M; 10 → hi-=M; 00/11 → hold; then arithmetic-shift {hi,lo,q} right 1.
  - Subtract is adder in0=hi, in1=~M, cin=1. Add is in1=M, cin=0.
  - E32 → DONE. E33 registers result=lo, exception=(hi != {32{lo[31]}}), RDY=1.
- DIV:
  - At E0, if B==0 → DONE. E1 registers result=0, exception=1, RDY=1.
  - If A==0x80000000 and B==0xFFFFFFFF → DONE. E1 registers result=0x80000000, exception=1, RDY=1.
  - Otherwise take magnitudes |A|, |B| as 32-bit unsigned. Negation is done combinationally at E0, not through the shared adder. Record sign=A[31]^B[31].
  - Iterations E1..E32: shift {R,Q} left 1 (R is 33 bits), then trial=R-|B|.
    - Low 32 bits of trial come from the adder (in0=R[31:0], in1=~|B|, cin=1).
    - Carry-out = overflow ^ out[31] ^ in0[31] ^ in1[31].
    - trial[32] = R[32] ^ 1 ^ carry-out.
    - trial[32]==0 → R=trial, Q[0]=1; else Q[0]=0.
  - E32 → FIX. E33: if sign, Q=~Q+1 via adder (in0=~Q, in1=0, cin=1); else hold.
  - E33 → DONE. E34 registers result=Q, exception=0, RDY=1.
  - Quotient truncates toward zero; remainder discarded.
- DONE: RDY high for exactly one cycle; next edge → IDLE, RDY=0. result/exception hold.
- busy: 1 from E0 until the edge that raises data_resultRDY.
- Adder input mux: selected by state only. IDLE/DONE drive in0=in1=0, cin=0.

Decomposition:
- Shared package holds:
  - state encodings (IDLE, MUL, DIV, FIX, DONE);
  - WIDTH, ITERS;
  - INT_MIN constant 0x80000000.
- Reuse the existing 32-bit carry-select adder as the single sub-module instance; no second adder.
- Booth-select and trial-sign logic stay inline.

Test Plan:
- Multiply 7 × -3, ctrl_MULT at E0 → RDY only at E33, result=0xFFFFFFEB, exception=0; RDY low at E34.
- Multiply 0x00010000 × 0x00010000 → result=0x00000000, exception=1 at E33; also 0x7FFFFFFF × 2 → exception=1.
- Divide -7 / 2 → RDY at E34, result=0xFFFFFFFD, exception=0; also 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- Divide 5 / 0 → RDY at E1, result=0, exception=1; divide 0x80000000 / 0xFFFFFFFF → RDY at E1, result=0x80000000, exception=1.
- Restart: ctrl_DIV 100/7 at E0, ctrl_MULT 6×7 at E10 → no RDY before E43; at E43 result=42, exception=0.
- Reset: assert reset asynchronously mid-MUL at E15 (between edges) → outputs 0 immediately; after release, no RDY until a new ctrl pulse.

Source files
------------

// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants and FSM encoding for the multi-cycle multiply/divide sequencer.
package multdiv_sequencer_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/multdiv_sequencer_csa.sv
// 32-bit carry-select adder: low half ripples, high half is precomputed for both
// carry-ins and picked by the low-half carry. Reports signed overflow.
module multdiv_sequencer_csa (
    input  logic [31:0] in0_i,
    input  logic [31:0] in1_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        ovf_o
);

    logic [16:0] lo_s;
    logic [15:0] hi0_s;
    logic [15:0] hi1_s;

    assign lo_s  = {1'b0, in0_i[15:0]} + {1'b0, in1_i[15:0]} + {16'd0, cin_i};
    assign hi0_s = in0_i[31:16] + in1_i[31:16];
    assign hi1_s = hi0_s + 16'd1;

    assign sum_o = {(lo_s[16] ? hi1_s : hi0_s), lo_s[15:0]};
    assign ovf_o = (in0_i[31] == in1_i[31]) && (sum_o[31] != in0_i[31]);

endmodule

// File: rtl/multdiv_sequencer.sv
// Signed 32-bit Booth multiply / restoring divide, iterating over one shared adder.
// Start pulses restart any operation in flight; completion is a one-cycle ready pulse.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_e state_q, state_d;

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // Booth high word / divide remainder
    logic [WIDTH-1:0] lo_q, lo_d;        // Booth low word / dividend-quotient
    logic [WIDTH-1:0] m_q, m_d;          // multiplicand / divisor magnitude
    logic             qb_q, qb_d;
    logic             sign_q, sign_d;
    logic             mul_q, mul_d;
    logic             xflag_q, xflag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] add_in0, add_in1, add_sum;
    logic             add_cin, add_ovf;

    logic             start;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             booth_op, booth_sub;
    logic [WIDTH-1:0] booth_hi;
    logic             booth_sign;
    logic             div_cout, trial_neg;

    multdiv_sequencer_csa u_adder (
        .in0_i (add_in0),
        .in1_i (add_in1),
        .cin_i (add_cin),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    assign start    = ctrl_MULT | ctrl_DIV;
    assign div_zero = (data_operandB == '0);
    assign div_ovf  = (data_operandA == INT_MIN) && (data_operandB == '1);
    assign abs_a    = data_operandA[WIDTH-1] ? (~data_operandA + 32'd1) : data_operandA;
    assign abs_b    = data_operandB[WIDTH-1] ? (~data_operandB + 32'd1) : data_operandB;

    assign booth_op   = lo_q[0] ^ qb_q;
    assign booth_sub  = lo_q[0] & ~qb_q;
    assign booth_hi   = booth_op ? add_sum : acc_q;
    // Shift in the true sign of hi+/-M so subtracting INT_MIN still shifts correctly.
    assign booth_sign = booth_op ? (add_sum[WIDTH-1] ^ add_ovf) : acc_q[WIDTH-1];

    assign div_cout  = add_ovf ^ add_sum[WIDTH-1] ^ add_in0[WIDTH-1] ^ add_in1[WIDTH-1];
    assign trial_neg = acc_q[WIDTH-1] ^ 1'b1 ^ div_cout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_MULT) begin
            state_d = ST_MUL;
        end else if (ctrl_DIV) begin
            state_d = (div_zero || div_ovf) ? ST_DONE : ST_DIV;
        end else begin
            case (state_q)
                ST_MUL:  if (count_q == CNT_W'(ITERS - 1)) state_d = ST_DONE;
                ST_DIV:  if (count_q == CNT_W'(ITERS - 1)) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        add_in0 = '0;
        add_in1 = '0;
        add_cin = 1'b0;
        case (state_q)
            ST_MUL: begin
                add_in0 = acc_q;
                add_in1 = booth_sub ? ~m_q : m_q;
                add_cin = booth_sub;
            end
            ST_DIV: begin
                add_in0 = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
                add_in1 = ~m_q;
                add_cin = 1'b1;
            end
            ST_FIX: begin
                add_in0 = ~lo_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        m_d      = m_q;
        qb_d     = qb_q;
        sign_d   = sign_q;
        mul_d    = mul_q;
        xflag_d  = xflag_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (start) begin
            count_d = '0;
            acc_d   = '0;
            qb_d    = 1'b0;
            mul_d   = ctrl_MULT;
            if (ctrl_MULT) begin
                lo_d    = data_operandA;
                m_d     = data_operandB;
                sign_d  = 1'b0;
                xflag_d = 1'b0;
            end else begin
                m_d     = abs_b;
                sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                xflag_d = div_zero | div_ovf;
                if (div_zero)     lo_d = '0;
                else if (div_ovf) lo_d = INT_MIN;
                else              lo_d = abs_a;
            end
        end else begin
            case (state_q)
                ST_MUL: begin
                    count_d = count_q + 1'b1;
                    acc_d   = {booth_sign, booth_hi[WIDTH-1:1]};
                    lo_d    = {booth_hi[0], lo_q[WIDTH-1:1]};
                    qb_d    = lo_q[0];
                end
                ST_DIV: begin
                    count_d = count_q + 1'b1;
                    acc_d   = trial_neg ? add_in0 : add_sum;
                    lo_d    = {lo_q[WIDTH-2:0], ~trial_neg};
                end
                ST_FIX: begin
                    if (sign_q) lo_d = add_sum;
                end
                ST_DONE: begin
                    result_d = lo_q;
                    exc_d    = mul_q ? (acc_q != {WIDTH{lo_q[WIDTH-1]}}) : xflag_q;
                    rdy_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            qb_q     <= 1'b0;
            sign_q   <= 1'b0;
            mul_q    <= 1'b0;
            xflag_q  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            qb_q     <= qb_d;
            sign_q   <= sign_d;
            mul_q    <= mul_d;
            xflag_q  <= xflag_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench: stimulus pushes expected result/exception/ready-edge, a negedge
// monitor pops and compares on every ready pulse.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          at_edge;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_cnt = 0;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_rdy", 32'(data_resultRDY), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("exception", 32'(data_exception), 32'(e.exc));
                check("rdy_edge", 32'(cyc), 32'(e.at_edge));
                check("busy_at_rdy", 32'(busy), 32'd0);
            end
        end
    end

    // Called just after a rising edge; the next rising edge is the start edge E0.
    task automatic issue(input bit mul, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] res, input bit exc, input int lat);
        exp_t e;
        ctrl_MULT     = mul;
        ctrl_DIV      = !mul;
        data_operandA = a;
        data_operandB = b;
        if (push) begin
            e.res     = res;
            e.exc     = exc;
            e.at_edge = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0BAD_F00D;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic run(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input bit exc);
        issue(mul, a, b, 1'b1, res, exc, mul ? 33 : ((b == 0 || (a == 32'h8000_0000 && b == '1)) ? 1 : 34));
        drain(60);
    endtask

    initial begin
        int rc;
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", 32'(data_exception), 32'd0);
        check("reset_rdy", 32'(data_resultRDY), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        issue(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0, 33);
        check("busy_after_start", 32'(busy), 32'd1);
        drain(60);
        run(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run(1'b1, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1);
        run(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,        1'b0);
        run(1'b1, 32'd3,         32'h8000_0000, 32'h8000_0000, 1'b1);
        run(1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        run(1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0);
        run(1'b0, 32'd100,       32'd7,         32'd14,        1'b0);
        run(1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run(1'b0, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0);
        run(1'b0, 32'd5,         32'd0,         32'd0,         1'b1);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Restart: divide aborted by a multiply issued ten edges later.
        issue(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 0);
        repeat (9) begin @(posedge clock); #1; end
        issue(1'b1, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, 33);
        drain(60);

        // Asynchronous reset in the middle of a multiply.
        issue(1'b1, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 0);
        repeat (14) begin @(posedge clock); #1; end
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        check("async_rst_result", data_result, 32'd0);
        check("async_rst_exc", 32'(data_exception), 32'd0);
        check("async_rst_rdy", 32'(data_resultRDY), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        rc = rdy_cnt;
        repeat (40) begin @(posedge clock); #1; end
        check("no_rdy_after_reset", 32'(rdy_cnt), 32'(rc));
        check("idle_after_reset", 32'(busy), 32'd0);

        run(1'b0, 32'd100, 32'd7, 32'd14, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
